// File: rtl/data_receiver.sv
// Destination-domain end of a 4-phase req/ack CDC handshake: synchronizes the
// request, captures the (quasi-static) data bus once, and holds ack until req drops.
module data_receiver #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_a,
  input  logic              i_rst_n,
  input  logic              i_data_req,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sink_ready,
  output logic              o_data_ack,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic [7:0]        o_xfer_cnt,
  output logic              o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  always_ff @(posedge i_clk_a or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_data_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // i_data is only sampled on a capture edge; req_s high guarantees it has settled.
  always_ff @(posedge i_clk_a or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_data_ack   <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_xfer_cnt   <= 8'd0;
      o_err        <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_s) begin
            if (i_sink_ready) begin
              o_data       <= i_data;
              o_data_valid <= 1'b1;
              o_data_ack   <= 1'b1;
              o_xfer_cnt   <= o_xfer_cnt + 8'd1;
              state        <= S_ACK;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A withdrawn request wins over a sink that just became ready.
          if (!req_s) begin
            o_err <= 1'b1;
            state <= S_IDLE;
          end else if (i_sink_ready) begin
            o_data       <= i_data;
            o_data_valid <= 1'b1;
            o_data_ack   <= 1'b1;
            o_xfer_cnt   <= o_xfer_cnt + 8'd1;
            state        <= S_ACK;
          end
        end
        S_ACK: begin
          if (!req_s) begin
            o_data_ack <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          o_data_ack <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
